// File: rtl/cmac_aes128_ctrl.sv
// AES-CMAC (RFC 4493) sequencer for one shared AES-128 core.
// Derives K1/K2, chains CBC-MAC over 128-bit blocks and emits the tag.
module cmac_aes128_ctrl #(
  parameter int AES_LAT = 43,
  parameter int CW      = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [127:0] i_blk_data,
  input  logic         i_blk_last,
  input  logic [4:0]   i_blk_len,
  output logic [127:0] o_tag,
  output logic         o_tag_valid,
  output logic         o_busy,
  output logic [127:0] o_k1,
  output logic [127:0] o_k2,
  output logic         o_aes_ld,
  output logic [127:0] o_aes_key,
  output logic [127:0] o_aes_text_in,
  input  logic [127:0] i_aes_text_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SUBKEY, S_DERIVE, S_WAIT_BLK, S_RUN, S_DONE
  } state_t;

  state_t         r_state;
  logic [127:0]   r_y;
  logic [127:0]   r_l;
  logic [CW-1:0]  r_cnt;
  logic           r_last;

  logic [127:0]   w_m;
  logic           w_handshake;
  logic           w_sample;

  // GF(2^128) doubling used for subkey derivation.
  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
  endfunction

  // Keep bytes 0..len-1, put 0x80 at byte len, zero the rest.
  function automatic logic [127:0] pad_block(input logic [127:0] d,
                                             input logic [4:0]   len);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(len))       p[127-8*i -: 8] = d[127-8*i -: 8];
      else if (i == int'(len)) p[127-8*i -: 8] = 8'h80;
    end
    return p;
  endfunction

  assign o_blk_ready = (r_state == S_WAIT_BLK);
  assign o_busy      = (r_state != S_IDLE);
  assign w_handshake = i_blk_valid && o_blk_ready;
  assign w_sample    = (r_cnt == CW'(AES_LAT));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_m = i_blk_data;
    if (i_blk_last) begin
      if (i_blk_len >= 5'd16) w_m = i_blk_data ^ o_k1;
      else                    w_m = pad_block(i_blk_data, i_blk_len) ^ o_k2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_y           <= '0;
      r_l           <= '0;
      r_cnt         <= '0;
      r_last        <= 1'b0;
      o_tag         <= '0;
      o_tag_valid   <= 1'b0;
      o_k1          <= '0;
      o_k2          <= '0;
      o_aes_ld      <= 1'b0;
      o_aes_key     <= '0;
      o_aes_text_in <= '0;
    end else begin
      o_aes_ld    <= 1'b0;
      o_tag_valid <= 1'b0;
      // Free-running; cleared on every load pulse so it measures from aes_ld.
      r_cnt       <= r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_aes_key     <= i_key;
            r_y           <= '0;
            o_aes_text_in <= '0;
            o_aes_ld      <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_SUBKEY;
          end
        end
        S_SUBKEY: begin
          if (w_sample) begin
            r_l     <= i_aes_text_out;
            r_state <= S_DERIVE;
          end
        end
        S_DERIVE: begin
          o_k1    <= dbl(r_l);
          o_k2    <= dbl(dbl(r_l));
          r_state <= S_WAIT_BLK;
        end
        S_WAIT_BLK: begin
          if (w_handshake) begin
            o_aes_text_in <= r_y ^ w_m;
            o_aes_ld      <= 1'b1;
            r_last        <= i_blk_last;
            r_cnt         <= '0;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_sample) begin
            r_y <= i_aes_text_out;
            if (r_last) begin
              o_tag       <= i_aes_text_out;
              o_tag_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_WAIT_BLK;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_aes128_ctrl.sv
// Directed bench for cmac_aes128_ctrl with a behavioural AES-128 core
// whose ciphertext is valid only in the exact sample cycle.
module tb_cmac_aes128_ctrl;
  localparam int AES_LAT = 43;

  logic         clk = 1'b0;
  logic         rst, start, blk_valid, blk_ready, blk_last;
  logic [127:0] key, blk_data, tag, k1, k2, aes_key, aes_text_in, aes_text_out;
  logic [4:0]   blk_len;
  logic         tag_valid, busy, aes_ld;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tagv   = 0;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] M0   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] M1   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] M2   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] M3   = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] EK1  = 128'hfbeed618357133667c85e08f7236a8de;
  localparam logic [127:0] EK2  = 128'hf7ddac306ae266ccf90bc11ee46d513b;
  localparam logic [127:0] T0   = 128'hbb1d6929e95937287fa37d129b756746;
  localparam logic [127:0] T16  = 128'h070a16b46b4d4144f79bdd9dd04a287c;
  localparam logic [127:0] T40  = 128'hdfa66747de9ae63030ca32611497c827;
  localparam logic [127:0] T64  = 128'h51f0bebf7e3b9d92fc49741779363cfe;

  always #5 clk = ~clk;

  cmac_aes128_ctrl #(.AES_LAT(AES_LAT), .CW(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key(key),
    .i_blk_valid(blk_valid), .o_blk_ready(blk_ready), .i_blk_data(blk_data),
    .i_blk_last(blk_last), .i_blk_len(blk_len), .o_tag(tag), .o_tag_valid(tag_valid),
    .o_busy(busy), .o_k1(k1), .o_k2(k2), .o_aes_ld(aes_ld), .o_aes_key(aes_key),
    .o_aes_text_in(aes_text_in), .i_aes_text_out(aes_text_out)
  );

  // ---------------- AES-128 reference core ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // Result is only presented in the single sample cycle; garbage otherwise.
  logic [127:0] core_res = '0;
  int           core_cnt = 0;
  always @(posedge clk) begin
    if (aes_ld === 1'b1) begin
      core_res <= aes128(aes_key, aes_text_in);
      core_cnt <= 1;
    end else if (core_cnt > 0 && core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign aes_text_out = (core_cnt == AES_LAT) ? core_res : (~core_res ^ 128'h5a5a_0000_ffff);

  always @(posedge clk) if (tag_valid === 1'b1) n_tagv <= n_tagv + 1;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start = 1'b1; key = k;
    tick();
    start = 1'b0; key = ~k;
  endtask

  task automatic wait_ready(output int cyc, output bit to);
    cyc = 0;
    while (blk_ready !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    to = (blk_ready !== 1'b1);
  endtask

  task automatic wait_tag(output int cyc, output bit to);
    cyc = 0;
    while (tag_valid !== 1'b1 && cyc < 300) begin tick(); cyc++; end
    to = (tag_valid !== 1'b1);
  endtask

  task automatic send_block(input logic [127:0] d, input bit last, input logic [4:0] len,
                            input int gap, output int cyc, output bit to);
    repeat (gap) tick();
    blk_valid = 1'b1; blk_data = d; blk_last = last; blk_len = len;
    wait_ready(cyc, to);
    tick();
    blk_valid = 1'b0; blk_data = {4{$urandom}}; blk_last = 1'b0; blk_len = 5'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; blk_valid = 1'b0; blk_data = '0;
    blk_last = 1'b0; blk_len = 5'd0;
    repeat (3) tick();
    n_checks++;
    if ({busy, blk_ready, tag_valid, aes_ld} !== 4'b0000 || tag !== '0 || k1 !== '0 ||
        k2 !== '0 || aes_text_in !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b ready=%b tv=%b ld=%b tag=%h k1=%h k2=%h tin=%h required all zero",
               busy, blk_ready, tag_valid, aes_ld, tag, k1, k2, aes_text_in);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_subkeys();
    int cyc; bit to;
    do_start(KEY);
    n_checks++;
    if (busy !== 1'b1 || aes_ld !== 1'b1 || aes_text_in !== '0 || aes_key !== KEY) begin
      n_fail++;
      $display("FAIL start_load: busy=%b ld=%b tin=%h key=%h required 1 1 0 %h",
               busy, aes_ld, aes_text_in, aes_key, KEY);
    end
    tick();
    n_checks++;
    if (aes_ld !== 1'b0) begin
      n_fail++; $display("FAIL ld_pulse_width: ld=%b required 0", aes_ld);
    end
    wait_ready(cyc, to);
    n_checks++;
    if (to || cyc != AES_LAT + 1) begin
      n_fail++; $display("FAIL subkey_latency: cycles=%0d timeout=%b required %0d", cyc + 1, to, AES_LAT + 2);
    end
    n_checks++;
    if (k1 !== EK1 || k2 !== EK2) begin
      n_fail++; $display("FAIL subkeys: k1=%h k2=%h required %h %h", k1, k2, EK1, EK2);
    end
  endtask

  task automatic test_empty();
    int cyc; bit to;
    send_block({4{32'hffffffff}}, 1'b1, 5'd0, 0, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || cyc != AES_LAT + 1) begin
      n_fail++; $display("FAIL empty_latency: cycles=%0d timeout=%b required %0d", cyc, to, AES_LAT + 1);
    end
    n_checks++;
    if (tag !== T0) begin
      n_fail++; $display("FAIL empty_tag: tag=%h required %h", tag, T0);
    end
    tick();
    n_checks++;
    if (tag_valid !== 1'b0 || busy !== 1'b0 || tag !== T0) begin
      n_fail++; $display("FAIL empty_after: tv=%b busy=%b tag=%h required 0 0 %h", tag_valid, busy, tag, T0);
    end
  endtask

  task automatic test_one_block();
    int cyc; bit to;
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b1, 5'd16, 0, cyc, to);
    // A start while busy must not disturb the running message.
    start = 1'b1; key = '0;
    tick();
    start = 1'b0;
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T16) begin
      n_fail++; $display("FAIL one_block_tag: tag=%h timeout=%b required %h", tag, to, T16);
    end
    tick();
    // blk_len above 16 is treated as a full block.
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b1, 5'd20, 0, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T16) begin
      n_fail++; $display("FAIL len20_tag: tag=%h timeout=%b required %h", tag, to, T16);
    end
    tick();
  endtask

  task automatic test_gaps_40();
    int cyc; bit to;
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b0, 5'd7, 0, cyc, to);
    n_checks++;
    if (blk_ready !== 1'b0 || aes_ld !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_ready_low: ready=%b ld=%b busy=%b required 0 1 1", blk_ready, aes_ld, busy);
    end
    send_block(M1, 1'b0, 5'd3, 5, cyc, to);
    n_checks++;
    if (to || cyc != AES_LAT + 1 - 5) begin
      n_fail++; $display("FAIL held_valid_wait: cycles=%0d timeout=%b required %0d", cyc, to, AES_LAT - 4);
    end
    send_block({64'h30c81c46a35ce411, 64'hdeadbeefcafef00d}, 1'b1, 5'd8, 17, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T40) begin
      n_fail++; $display("FAIL msg40_tag: tag=%h timeout=%b required %h", tag, to, T40);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b0, 5'd0, 0, cyc, to);
    send_block(M1, 1'b0, 5'd0, 0, cyc, to);
    n_checks++;
    if (to || cyc != AES_LAT + 1) begin
      n_fail++; $display("FAIL block_latency: cycles=%0d timeout=%b required %0d", cyc, to, AES_LAT + 1);
    end
    send_block(M2, 1'b0, 5'd0, 0, cyc, to);
    send_block(M3, 1'b1, 5'd16, 0, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T64) begin
      n_fail++; $display("FAIL msg64_tag: tag=%h timeout=%b required %h", tag, to, T64);
    end
    tick();
    do_start(KEY);
    n_checks++;
    if (busy !== 1'b1 || aes_ld !== 1'b1) begin
      n_fail++; $display("FAIL b2b_start: busy=%b ld=%b required 1 1", busy, aes_ld);
    end
    wait_ready(cyc, to);
    send_block(M0, 1'b1, 5'd16, 0, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T16 || k1 !== EK1) begin
      n_fail++; $display("FAIL b2b_second_tag: tag=%h k1=%h timeout=%b required %h %h", tag, k1, to, T16, EK1);
    end
    tick();
  endtask

  task automatic test_abort_reset();
    int cyc; bit to; int tv_before;
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b0, 5'd0, 0, cyc, to);
    send_block(M1, 1'b0, 5'd0, 0, cyc, to);
    repeat (10) tick();
    tv_before = n_tagv;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, blk_ready, tag_valid, aes_ld} !== 4'b0000 || tag !== T16 && tag !== '0 ||
        k1 !== '0 || k2 !== '0 || aes_text_in !== '0 || tag !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b ready=%b tv=%b ld=%b tag=%h k1=%h k2=%h tin=%h required all zero",
               busy, blk_ready, tag_valid, aes_ld, tag, k1, k2, aes_text_in);
    end
    repeat (60) tick();
    n_checks++;
    if (n_tagv != tv_before || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_tag: pulses=%0d busy=%b required %0d 0", n_tagv, busy, tv_before);
    end
    do_start(KEY);
    wait_ready(cyc, to);
    send_block(M0, 1'b1, 5'd16, 0, cyc, to);
    wait_tag(cyc, to);
    n_checks++;
    if (to || tag !== T16) begin
      n_fail++; $display("FAIL abort_rerun_tag: tag=%h timeout=%b required %h", tag, to, T16);
    end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_subkeys();
    test_empty();
    test_one_block();
    test_gaps_40();
    test_back_to_back();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
